// File: rtl/au_pkg.sv
// Shared opcode encoding, FSM state type and opcode legality check for the
// sequential arithmetic unit.
package au_pkg;

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MOVA = 4'b0100;
  localparam logic [3:0] OP_MOVB = 4'b0101;
  localparam logic [3:0] OP_OUT  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MOVA, OP_MOVB, OP_OUT, OP_MUL: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/au_mul_shift.sv
// Unsigned shift-add multiplier: one partial-product step per enabled edge,
// multiplier LSB first, finishing after W steps.
module au_mul_shift #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           last,
  output logic [2*W-1:0] product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  r_mcand;
  logic [W-1:0]  r_mplier;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_sum;

  assign w_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});

  // product is the value the {acc, mplier} pair takes after the current step,
  // so the caller can capture the finished result on the final step edge.
  assign product = {w_sum, r_mplier[W-1:1]};
  assign last    = step && (r_cnt == CW'(W-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (step) begin
      r_acc    <= w_sum[W:1];
      r_mplier <= {w_sum[0], r_mplier[W-1:1]};
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/au_seq.sv
// Registered arithmetic unit with start/done handshake, flags, a multi-cycle
// multiply and tri-stated bus outputs.
module au_seq
  import au_pkg::*;
#(
  parameter int W    = 8,
  parameter int AC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AC_W-1:0] ac,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic            au_en,
  output logic [W-1:0]    t,
  output logic [W-1:0]    t_hi,
  output logic            gf,
  output logic            cf,
  output logic            zf,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t r_state, w_state_next;

  logic [W-1:0] r_res, r_hi, w_res, w_hi;
  logic         r_gf, r_cf, r_zf, r_done, r_err;
  logic         w_gf, w_cf, w_zf, w_done, w_err;

  logic [3:0]     w_op;
  logic           w_hi_ok;
  logic           w_legal;
  logic           w_load;
  logic           w_step;
  logic           w_last;
  logic [2*W-1:0] w_product;
  logic [W-1:0]   w_add_sum;
  logic           w_add_c;

  assign w_op = ac[3:0];

  // Wider opcode fields are only legal when the bits above the 4-bit code are zero.
  if (AC_W > 4) begin : g_ac_wide
    assign w_hi_ok = (ac[AC_W-1:4] == '0);
  end else begin : g_ac_narrow
    assign w_hi_ok = 1'b1;
  end

  assign w_legal              = w_hi_ok && is_legal(w_op);
  assign {w_add_c, w_add_sum} = {1'b0, a} + {1'b0, b};

  assign w_load = (r_state == IDLE) && start && w_legal && (w_op == OP_MUL);
  assign w_step = (r_state == MUL);

  au_mul_shift #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .step    (w_step),
    .a       (a),
    .b       (b),
    .last    (w_last),
    .product (w_product)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left one
    // unassigned would infer a latch.
    w_state_next = r_state;
    w_res        = r_res;
    w_hi         = r_hi;
    w_gf         = r_gf;
    w_cf         = r_cf;
    w_zf         = r_zf;
    w_err        = r_err;
    w_done       = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (!w_legal) begin
            w_err  = 1'b1;
            w_done = 1'b1;
          end else if (w_op == OP_MUL) begin
            w_err        = 1'b0;
            w_state_next = MUL;
          end else begin
            w_err  = 1'b0;
            w_done = 1'b1;
            w_hi   = '0;
            w_gf   = 1'b0;
            w_cf   = 1'b0;
            case (w_op)
              OP_ADD: begin
                w_res = w_add_sum;
                w_cf  = w_add_c;
              end
              OP_SUB: begin
                w_res = b - a;
                w_gf  = (b > a);
                w_cf  = (b < a);
              end
              default: w_res = a;
            endcase
            w_zf = (w_res == '0);
          end
        end
      end
      MUL: begin
        if (w_last) begin
          w_res        = w_product[W-1:0];
          w_hi         = w_product[2*W-1:W];
          w_zf         = (w_product == '0);
          w_gf         = 1'b0;
          w_cf         = 1'b0;
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_res   <= '0;
      r_hi    <= '0;
      r_gf    <= 1'b0;
      r_cf    <= 1'b0;
      r_zf    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_res   <= w_res;
      r_hi    <= w_hi;
      r_gf    <= w_gf;
      r_cf    <= w_cf;
      r_zf    <= w_zf;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign t    = au_en ? r_res : {W{1'bz}};
  assign t_hi = au_en ? r_hi  : {W{1'bz}};
  assign gf   = r_gf;
  assign cf   = r_cf;
  assign zf   = r_zf;
  assign busy = (r_state == MUL);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_au_seq.sv
// Self-checking bench for au_seq: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_au_seq;

  localparam int W    = 8;
  localparam int AC_W = 4;

  localparam logic [3:0] C_ADD  = 4'b1000;
  localparam logic [3:0] C_SUB  = 4'b1001;
  localparam logic [3:0] C_MOVA = 4'b0100;
  localparam logic [3:0] C_MOVB = 4'b0101;
  localparam logic [3:0] C_OUT  = 4'b1101;
  localparam logic [3:0] C_MUL  = 4'b1010;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AC_W-1:0] ac;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic            au_en;
  wire  [W-1:0]    t;
  wire  [W-1:0]    t_hi;
  logic            gf, cf, zf, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  int m_res, m_hi;
  bit m_gf, m_cf, m_zf, m_err;

  logic [3:0] legal_ops [6] = '{C_ADD, C_SUB, C_MOVA, C_MOVB, C_OUT, C_MUL};

  always #5 clk = ~clk;

  au_seq #(.W(W), .AC_W(AC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ac    (ac),
    .a     (a),
    .b     (b),
    .au_en (au_en),
    .t     (t),
    .t_hi  (t_hi),
    .gf    (gf),
    .cf    (cf),
    .zf    (zf),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_res = 0; m_hi = 0;
    m_gf = 0; m_cf = 0; m_zf = 0; m_err = 0;
  endtask

  task automatic model_op(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int ix, iy, p;
    ix = int'(x);
    iy = int'(y);
    case (op)
      C_ADD: begin
        m_res = (ix + iy) % 256; m_cf = (ix + iy) > 255; m_gf = 0; m_hi = 0;
        m_zf = (m_res == 0); m_err = 0;
      end
      C_SUB: begin
        m_res = (iy - ix) & 255; m_gf = iy > ix; m_cf = iy < ix; m_hi = 0;
        m_zf = (m_res == 0); m_err = 0;
      end
      C_MOVA, C_MOVB, C_OUT: begin
        m_res = ix; m_gf = 0; m_cf = 0; m_hi = 0; m_zf = (m_res == 0); m_err = 0;
      end
      C_MUL: begin
        p = ix * iy;
        m_res = p % 256; m_hi = p / 256; m_zf = (p == 0); m_gf = 0; m_cf = 0; m_err = 0;
      end
      default: m_err = 1;
    endcase
  endtask

  task automatic check_state(input string tag);
    logic [7:0] et, eh;
    et = au_en ? 8'(m_res) : 8'bz;
    eh = au_en ? 8'(m_hi)  : 8'bz;
    check({tag, "_t"},    t,    et);
    check({tag, "_thi"},  t_hi, eh);
    check({tag, "_gf"},   gf,   m_gf);
    check({tag, "_cf"},   cf,   m_cf);
    check({tag, "_zf"},   zf,   m_zf);
    check({tag, "_err"},  err,  m_err);
  endtask

  // Entered just after a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] x,
                        input logic [7:0] y);
    int lat;
    ac = op; a = x; b = y; start = 1'b1;
    model_op(op, x, y);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    if (op != C_MUL) begin
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy"}, busy, 1'b0);
      check_state(tag);
    end else begin
      lat = -1;
      for (int n = 1; n <= W + 4; n++) begin
        check({tag, "_busy_hi"}, busy, 1'b1);
        start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); ac = 4'($urandom);
        @(posedge clk); @(negedge clk);
        if (done) begin
          lat = n;
          break;
        end
      end
      start = 1'b0;
      check({tag, "_latency"}, lat, W);
      if (lat >= 0) begin
        check({tag, "_busy_lo"}, busy, 1'b0);
        check_state(tag);
      end
    end
  endtask

  task automatic idle(input string tag);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, "_done_lo"}, done, 1'b0);
    check({tag, "_busy_lo"}, busy, 1'b0);
    check_state(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic [7:0] x, y;

    rst = 1'b1; start = 1'b0; ac = '0; a = '0; b = '0; au_en = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_state("rst");
    rst = 1'b0;
    @(negedge clk);

    run_op("add_ff_01", C_ADD, 8'hFF, 8'h01);
    idle("add_after");
    run_op("sub_05_10", C_SUB, 8'h05, 8'h10);
    run_op("sub_10_05", C_SUB, 8'h10, 8'h05);
    run_op("sub_eq", C_SUB, 8'h33, 8'h33);
    idle("sub_after");

    run_op("mul_200_3", C_MUL, 8'd200, 8'd3);
    idle("mul_after");
    run_op("mul_12_13", C_MUL, 8'd12, 8'd13);
    run_op("out_b2b", C_OUT, 8'h7E, 8'h00);
    idle("out_after");
    run_op("mul_max", C_MUL, 8'hFF, 8'hFF);
    run_op("mul_zero", C_MUL, 8'h00, 8'h5A);

    run_op("add_3_4", C_ADD, 8'h03, 8'h04);
    run_op("illegal", 4'b0000, 8'hAA, 8'h55);
    idle("illegal_after");
    run_op("clear_err", C_MOVB, 8'h00, 8'h99);

    au_en = 1'b0;
    idle("hiz");
    au_en = 1'b1;

    ac = C_MUL; a = 8'd77; b = 8'd91; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check_state("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    idle("rst_mid_after");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom);
      else                           op = legal_ops[$urandom_range(0, 5)];
      x = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      y = ($urandom_range(0, 5) == 0) ? x     : 8'($urandom);
      au_en = ($urandom_range(0, 3) != 0);
      run_op("rnd", op, x, y);
      if ($urandom_range(0, 1) == 0) idle("rnd_idle");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
